// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants (640x480@60 defaults) and timing helper functions.
// Used by the counter, interface and top of the vga_timing_gen slice.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_LOOKAHEAD = 4;
  localparam int DEF_XW        = 10;
  localparam int DEF_YW        = 10;
  localparam int DEF_FCW       = 8;

  function automatic int calc_total(input int active, input int fp, input int sync,
                                    input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic bit is_active(input int h, input int v, input int h_active,
                                   input int v_active);
    return (h < h_active) && (v < v_active);
  endfunction

  function automatic bit in_hsync(input int h, input int h_active, input int h_fp,
                                  input int h_sync);
    return (h >= h_active + h_fp) && (h < h_active + h_fp + h_sync);
  endfunction

  // Evaluated per line, so vsync edges always land on h=0.
  function automatic bit in_vsync(input int v, input int v_active, input int v_fp,
                                  input int v_sync);
    return (v >= v_active + v_fp) && (v < v_active + v_fp + v_sync);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: syncs, blank, position, pulses, prefetch request, frame count.
// master drives (timing generator), slave consumes (display / prefetch logic).
interface vga_timing_gen_if #(
  parameter int XW  = 10,
  parameter int YW  = 10,
  parameter int FCW = 8
) ();

  logic           hsync;
  logic           vsync;
  logic           comp_sync;
  logic           blank;
  logic [XW-1:0]  pixel_x;
  logic [YW-1:0]  pixel_y;
  logic           line_start;
  logic           frame_start;
  logic           fetch_req;
  logic [FCW-1:0] frame_cnt;

  modport master (
    output hsync, vsync, comp_sync, blank, pixel_x, pixel_y,
           line_start, frame_start, fetch_req, frame_cnt
  );

  modport slave (
    input hsync, vsync, comp_sync, blank, pixel_x, pixel_y,
          line_start, frame_start, fetch_req, frame_cnt
  );

endinterface

// File: rtl/vga_timing_gen_scan_counter.sv
// h/v raster counter pair with line/frame wrap, advance enable and park-to-start.
// Exposes the next-state position so callers can register outputs in the same edge.
module vga_scan_counter #(
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_START = 0,
  parameter int V_START = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          park,
  output logic [XW-1:0] h_nxt,
  output logic [YW-1:0] v_nxt
);

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_INIT = XW'(H_START);
  localparam logic [YW-1:0] V_INIT = YW'(V_START);

  logic [XW-1:0] h_q;
  logic [YW-1:0] v_q;

  always_comb begin
    h_nxt = h_q;
    v_nxt = v_q;
    if (park) begin
      h_nxt = H_INIT;
      v_nxt = V_INIT;
    end else if (adv) begin
      if (h_q == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_q == V_LAST) ? '0 : v_q + YW'(1);
      end else begin
        h_nxt = h_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= H_INIT;
      v_q <= V_INIT;
    end else begin
      h_q <= h_nxt;
      v_q <= v_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel-clock enable, run/park control and prefetch lead.
// Outputs registered on the same ce edge as the counters; ce=0 holds state, pulses drop after one clk.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int LOOKAHEAD = DEF_LOOKAHEAD,
  parameter int XW        = DEF_XW,
  parameter int YW        = DEF_YW,
  parameter int FCW       = DEF_FCW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              en,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      XW == 0 || YW == 0 || FCW == 0) begin : g_bad_zero
    $error("vga_timing_gen: timing field or width is zero");
  end
  if (LOOKAHEAD < 1 || LOOKAHEAD >= H_TOTAL) begin : g_bad_lookahead
    $error("vga_timing_gen: LOOKAHEAD must be 1..H_TOTAL-1");
  end
  if (((H_TOTAL - 1) >> XW) != 0 || ((V_TOTAL - 1) >> YW) != 0) begin : g_bad_width
    $error("vga_timing_gen: XW/YW too narrow for the raster totals");
  end

  // running=0 after reset or park: the first enabled ce shows (0,0) instead of stepping past it.
  logic running;
  logic adv;
  logic park;

  assign adv  = ce & en & running;
  assign park = ce & ~en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
    end else if (ce) begin
      running <= en;
    end
  end

  logic [XW-1:0] m_h_nxt;
  logic [YW-1:0] m_v_nxt;
  logic [XW-1:0] l_h_nxt;
  logic [YW-1:0] l_v_nxt;

  vga_scan_counter #(
    .XW(XW), .YW(YW), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .H_START(0), .V_START(0)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .adv(adv), .park(park),
    .h_nxt(m_h_nxt), .v_nxt(m_v_nxt)
  );

  // Lead pair runs LOOKAHEAD ticks ahead and wraps across lines and frames.
  vga_scan_counter #(
    .XW(XW), .YW(YW), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .H_START(LOOKAHEAD), .V_START(0)
  ) u_lead (
    .clk(clk), .rst_n(rst_n), .adv(adv), .park(park),
    .h_nxt(l_h_nxt), .v_nxt(l_v_nxt)
  );

  logic active_nxt;
  logic hs_act_nxt;
  logic vs_act_nxt;
  logic fetch_nxt;
  logic h_zero_nxt;
  logic v_zero_nxt;

  always_comb begin
    active_nxt = is_active(int'(m_h_nxt), int'(m_v_nxt), H_ACTIVE, V_ACTIVE);
    hs_act_nxt = in_hsync(int'(m_h_nxt), H_ACTIVE, H_FP, H_SYNC);
    vs_act_nxt = in_vsync(int'(m_v_nxt), V_ACTIVE, V_FP, V_SYNC);
    fetch_nxt  = is_active(int'(l_h_nxt), int'(l_v_nxt), H_ACTIVE, V_ACTIVE);
    h_zero_nxt = (m_h_nxt == '0);
    v_zero_nxt = (m_v_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.pixel_x     <= '0;
      vga.pixel_y     <= '0;
      vga.blank       <= 1'b1;
      vga.hsync       <= ~HS_POL;
      vga.vsync       <= ~VS_POL;
      vga.comp_sync   <= 1'b1;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.fetch_req   <= 1'b0;
      vga.frame_cnt   <= '0;
    end else if (ce) begin
      if (!en) begin
        vga.pixel_x     <= '0;
        vga.pixel_y     <= '0;
        vga.blank       <= 1'b1;
        vga.hsync       <= ~HS_POL;
        vga.vsync       <= ~VS_POL;
        vga.comp_sync   <= 1'b1;
        vga.line_start  <= 1'b0;
        vga.frame_start <= 1'b0;
        vga.fetch_req   <= 1'b0;
      end else begin
        vga.pixel_x     <= m_h_nxt;
        vga.pixel_y     <= m_v_nxt;
        vga.blank       <= ~active_nxt;
        vga.hsync       <= hs_act_nxt ? HS_POL : ~HS_POL;
        vga.vsync       <= vs_act_nxt ? VS_POL : ~VS_POL;
        vga.comp_sync   <= ~(hs_act_nxt | vs_act_nxt);
        vga.line_start  <= h_zero_nxt;
        vga.frame_start <= h_zero_nxt & v_zero_nxt;
        vga.fetch_req   <= fetch_nxt;
        if (adv && h_zero_nxt && v_zero_nxt) begin
          vga.frame_cnt <= vga.frame_cnt + FCW'(1);
        end
      end
    end else begin
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: 16x8 raster (H 8/2/2/4, V 4/1/1/2, LOOKAHEAD=3) on two instances,
// one with active-low syncs and one with active-high syncs, sharing all inputs.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  logic en;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW(10), .YW(10), .FCW(8)) vif0 ();
  vga_timing_gen_if #(.XW(10), .YW(10), .FCW(8)) vif1 ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(3),
    .XW(10), .YW(10), .FCW(8)
  ) dut0 (.clk(clk), .rst_n(rst_n), .ce(ce), .en(en), .vga(vif0));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOOKAHEAD(3),
    .XW(10), .YW(10), .FCW(8)
  ) dut1 (.clk(clk), .rst_n(rst_n), .ce(ce), .en(en), .vga(vif1));

  int n_checks = 0;
  int n_fail   = 0;
  // Reference raster position: linear index 0..127 into the 16x8 frame.
  int pos      = 0;
  int fcnt     = 0;
  bit started  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit stall);
    int h, v, lp;
    bit hs, vs, e_blank, e_ls, e_fs, e_fetch;
    h  = pos % 16;
    v  = pos / 16;
    lp = (pos + 3) % 128;
    hs = started && (h == 10 || h == 11);
    vs = started && (v == 5);
    e_blank = started ? !(h < 8 && v < 4) : 1'b1;
    e_ls    = started && !stall && (h == 0);
    e_fs    = started && !stall && (pos == 0);
    e_fetch = started && ((lp % 16) < 8) && ((lp / 16) < 4);
    chk("pixel_x",     vif0.pixel_x,     started ? h : 0);
    chk("pixel_y",     vif0.pixel_y,     started ? v : 0);
    chk("blank",       vif0.blank,       e_blank);
    chk("hsync_lo",    vif0.hsync,       !hs);
    chk("vsync_lo",    vif0.vsync,       !vs);
    chk("comp_sync",   vif0.comp_sync,   !(hs || vs));
    chk("line_start",  vif0.line_start,  e_ls);
    chk("frame_start", vif0.frame_start, e_fs);
    chk("fetch_req",   vif0.fetch_req,   e_fetch);
    chk("frame_cnt",   vif0.frame_cnt,   fcnt);
    chk("hsync_hi",    vif1.hsync,       hs);
    chk("vsync_hi",    vif1.vsync,       vs);
    chk("comp_sync_hi", vif1.comp_sync,  !(hs || vs));
    chk("blank_hi",    vif1.blank,       e_blank);
  endtask

  // One clock with the given ce; update the reference position, then check both instances.
  task automatic step(input bit ce_v);
    ce = ce_v;
    @(posedge clk);
    #1;
    if (ce_v) begin
      if (en) begin
        if (!started) begin
          started = 1'b1;
          pos = 0;
        end else begin
          pos = (pos + 1) % 128;
          if (pos == 0) fcnt = (fcnt + 1) % 256;
        end
      end else begin
        started = 1'b0;
      end
    end
    check_all(!ce_v);
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b0;
    en    = 1'b0;
    #12;
    check_all(1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Three full frames plus the return to (0,0).
    repeat (385) step(1'b1);
    chk("frame_cnt_3_frames", vif0.frame_cnt, 3);

    // ce on every 4th clk: three held clks between ticks.
    repeat (10) begin
      step(1'b1);
      repeat (3) step(1'b0);
    end

    // Run to (h=6, v=2), then drop en.
    for (int i = 0; i < 200 && !(started && pos == 38); i++) step(1'b1);
    chk("at_h6_v2_x", vif0.pixel_x, 6);
    en = 1'b0;
    step(1'b1);
    chk("park_frame_cnt_hold", vif0.frame_cnt, fcnt);
    step(1'b1);
    step(1'b0);
    en = 1'b1;
    step(1'b1);
    chk("restart_frame_start", vif0.frame_start, 1);
    repeat (20) step(1'b1);

    // Reset asserted mid-hsync.
    for (int i = 0; i < 40 && !(started && (pos % 16) == 10); i++) step(1'b1);
    chk("pre_reset_hsync_lo", vif0.hsync, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_hsync_lo", vif0.hsync, 1);
    chk("async_hsync_hi", vif1.hsync, 0);
    started = 1'b0;
    pos     = 0;
    fcnt    = 0;
    check_all(1'b1);
    #2;
    rst_n = 1'b1;
    step(1'b1);
    chk("post_reset_frame_start", vif0.frame_start, 1);
    repeat (5) step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
